// File: rtl/reg_write_buffer.sv
// reg_write_buffer: in-order register write FIFO with register-file drain and youngest-match read bypass
module reg_write_buffer #(
  parameter int DEPTH  = 4,
  parameter int DATA_W = 16,
  parameter int ADDR_W = 2
) (
  input  logic                       clock,
  input  logic                       reset_n,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [ADDR_W-1:0]          in_wr,
  input  logic [DATA_W-1:0]          in_wd,
  input  logic                       rf_hold,
  output logic                       rf_regwrite,
  output logic [ADDR_W-1:0]          rf_wr,
  output logic [DATA_W-1:0]          rf_wd,
  input  logic [ADDR_W-1:0]          rr1,
  input  logic [ADDR_W-1:0]          rr2,
  output logic                       byp_hit1,
  output logic [DATA_W-1:0]          byp_data1,
  output logic                       byp_hit2,
  output logic [DATA_W-1:0]          byp_data2,
  output logic [$clog2(DEPTH+1)-1:0] count
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  logic [ADDR_W-1:0] mem_wr [DEPTH];
  logic [DATA_W-1:0] mem_wd [DEPTH];
  logic [PW-1:0] rd_ptr, wr_ptr;
  logic push, pop;
  assign in_ready    = count != CW'(DEPTH);
  assign push        = in_valid & in_ready & (in_wr != '0);
  assign rf_regwrite = (count != '0) & ~rf_hold;
  assign pop         = rf_regwrite;
  assign rf_wr       = count != '0 ? mem_wr[rd_ptr] : '0;
  assign rf_wd       = count != '0 ? mem_wd[rd_ptr] : '0;
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      wr_ptr <= wr_ptr + PW'(push);
      rd_ptr <= rd_ptr + PW'(pop);
      count  <= count + CW'(push) - CW'(pop);
    end
  always_ff @(posedge clock)
    if (push) begin
      mem_wr[wr_ptr] <= in_wr;
      mem_wd[wr_ptr] <= in_wd;
    end
  always_comb begin
    byp_hit1  = 1'b0;
    byp_data1 = '0;
    byp_hit2  = 1'b0;
    byp_data2 = '0;
    for (int i = 0; i < DEPTH; i++)
      if (CW'(i) < count) begin
        if (rr1 != '0 && mem_wr[rd_ptr + PW'(i)] == rr1) begin
          byp_hit1  = 1'b1;
          byp_data1 = mem_wd[rd_ptr + PW'(i)];
        end
        if (rr2 != '0 && mem_wr[rd_ptr + PW'(i)] == rr2) begin
          byp_hit2  = 1'b1;
          byp_data2 = mem_wd[rd_ptr + PW'(i)];
        end
      end
  end
endmodule

// File: tb/tb_reg_write_buffer.sv
// tb_reg_write_buffer: scoreboard bench for reg_write_buffer
module tb_reg_write_buffer;
  logic clock = 1'b0, reset_n = 1'b0;
  logic in_valid = 1'b0, in_ready;
  logic [1:0] in_wr = '0, rf_wr, rr1 = '0, rr2 = '0;
  logic [15:0] in_wd = '0, rf_wd, byp_data1, byp_data2;
  logic rf_hold = 1'b0, rf_regwrite, byp_hit1, byp_hit2;
  logic [2:0] count;
  logic [17:0] exp_q [$];
  logic [17:0] e;
  int total = 0, passed = 0;
  bit osc = 0, rand_hold = 0;
  reg_write_buffer dut (
    .clock(clock), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_wr(in_wr), .in_wd(in_wd), .rf_hold(rf_hold), .rf_regwrite(rf_regwrite),
    .rf_wr(rf_wr), .rf_wd(rf_wd), .rr1(rr1), .rr2(rr2), .byp_hit1(byp_hit1),
    .byp_data1(byp_data1), .byp_hit2(byp_hit2), .byp_data2(byp_data2), .count(count)
  );
  always #5 clock = ~clock;
  task automatic chk(string name, logic [31:0] act, logic [31:0] req);
    total++;
    if (act === req) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, req);
  endtask
  // monitor: every presented register-file write must match the oldest expected entry
  always @(negedge clock)
    if (reset_n) begin
      if (rf_regwrite) begin
        if (exp_q.size() == 0) chk("unexpected_commit", {14'd0, rf_wr, rf_wd}, 32'h0);
        else begin
          e = exp_q.pop_front();
          chk("commit", {14'd0, rf_wr, rf_wd}, {14'd0, e});
        end
      end
      if (osc) begin
        total++;
        if (count >= 3) passed++;
        else $display("FAIL osc_count: got %0d expected 3 or 4", count);
      end
    end
  always @(posedge clock) begin
    #1;
    if (rand_hold) rf_hold = 1'($urandom_range(0, 1));
  end
  // drive a request, hold it until accepted; in_valid stays high for back-to-back use
  task automatic send(logic [1:0] wr, logic [15:0] wd);
    bit done = 0;
    in_valid = 1'b1;
    in_wr = wr;
    in_wd = wd;
    for (int c = 0; c < 40 && !done; c++) begin
      @(negedge clock);
      if (in_ready) begin
        if (wr != 0) exp_q.push_back({wr, wd});
        done = 1;
      end
      @(posedge clock);
      #1;
    end
    if (!done) chk("send_timeout", 0, 1);
  endtask
  task automatic drain();
    bit done = 0;
    for (int c = 0; c < 60 && !done; c++) begin
      @(posedge clock);
      #2;
      done = count == 0 && exp_q.size() == 0;
    end
    chk("drain_count", 32'(count), 0);
    chk("drain_queue", exp_q.size(), 0);
  endtask
  initial begin
    #3;
    chk("rst_count", 32'(count), 0);
    chk("rst_ready", 32'(in_ready), 1);
    chk("rst_regwrite", 32'(rf_regwrite), 0);
    chk("rst_wr", 32'(rf_wr), 0);
    chk("rst_wd", 32'(rf_wd), 0);
    chk("rst_hit1", 32'(byp_hit1), 0);
    chk("rst_hit2", 32'(byp_hit2), 0);
    repeat (2) @(posedge clock);
    #1 reset_n = 1'b1;
    repeat (2) @(posedge clock);
    #1;
    chk("idle_count", 32'(count), 0);
    chk("idle_ready", 32'(in_ready), 1);
    chk("idle_regwrite", 32'(rf_regwrite), 0);
    rr1 = 2;
    send(2, 16'h1234);
    in_valid = 0;
    chk("single_regwrite", 32'(rf_regwrite), 1);
    chk("single_wr", 32'(rf_wr), 2);
    chk("single_wd", 32'(rf_wd), 32'h1234);
    chk("single_hit1", 32'(byp_hit1), 1);
    chk("single_data1", 32'(byp_data1), 32'h1234);
    chk("single_count", 32'(count), 1);
    @(posedge clock);
    #1;
    chk("single_count_after", 32'(count), 0);
    chk("single_hit1_after", 32'(byp_hit1), 0);
    rf_hold = 1;
    send(1, 16'hA);
    send(2, 16'hB);
    send(3, 16'hC);
    send(1, 16'hD);
    in_valid = 0;
    chk("full_count", 32'(count), 4);
    chk("full_ready", 32'(in_ready), 0);
    rr1 = 1;
    rr2 = 3;
    #1;
    chk("full_hit1", 32'(byp_hit1), 1);
    chk("full_data1", 32'(byp_data1), 32'hD);
    chk("full_data2", 32'(byp_data2), 32'hC);
    in_valid = 1;
    in_wr = 2;
    in_wd = 16'hE;
    repeat (3) @(posedge clock);
    #1;
    chk("fifth_count", 32'(count), 4);
    chk("fifth_ready", 32'(in_ready), 0);
    in_valid = 0;
    rf_hold = 0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clock);
      #1;
      chk("release_count", 32'(count), 32'(3 - i));
    end
    rr2 = 0;
    send(0, 16'hFFFF);
    in_valid = 0;
    chk("r0_ready", 32'(in_ready), 1);
    chk("r0_count", 32'(count), 0);
    chk("r0_hit2", 32'(byp_hit2), 0);
    repeat (3) @(posedge clock);
    #1;
    chk("r0_count_later", 32'(count), 0);
    rf_hold = 1;
    for (int i = 0; i < 4; i++) send(2'($urandom_range(1, 3)), 16'($urandom));
    in_valid = 0;
    chk("osc_full", 32'(count), 4);
    rf_hold = 0;
    osc = 1;
    for (int i = 0; i < 20; i++) send(2'($urandom_range(1, 3)), 16'($urandom));
    in_valid = 0;
    osc = 0;
    drain();
    rand_hold = 1;
    for (int i = 0; i < 13; i++) send(2'($urandom_range(0, 3)), 16'($urandom));
    in_valid = 0;
    @(posedge clock);
    rand_hold = 0;
    #2 rf_hold = 0;
    drain();
    rf_hold = 1;
    send(1, 16'h11);
    send(2, 16'h22);
    send(3, 16'h33);
    in_valid = 0;
    chk("pre_reset_count", 32'(count), 3);
    #2 reset_n = 0;
    #1;
    chk("async_rst_count", 32'(count), 0);
    chk("async_rst_regwrite", 32'(rf_regwrite), 0);
    chk("async_rst_ready", 32'(in_ready), 1);
    chk("async_rst_hit1", 32'(byp_hit1), 0);
    exp_q.delete();
    rf_hold = 0;
    @(posedge clock);
    #1 reset_n = 1;
    repeat (3) @(posedge clock);
    #1;
    chk("post_reset_count", 32'(count), 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
